taillight_sequencer: RTL

- Central controller for the DE10-Lite sequential taillight datapath.
- Synchronizes the hazard, turn-enable, turn-direction and brake controls, and resolves them by priority into one of seven lamp modes.
- Steps a free-running tick-driven pattern across the three left and three right lamps.
- Drives led_l/led_r (top level maps these to LEDR[9:7]/LEDR[2:0]) and a mode code for the HEX5 decoder.

---
 rtl/taillight_pkg.sv | 92 +++++++++
 rtl/tick_divider.sv | 30 +++
 rtl/taillight_sequencer.sv | 80 ++++++++
 3 files changed

// File: rtl/taillight_pkg.sv
// Shared mode codes, lamp patterns and decode helpers for the taillight sequencer.
package taillight_pkg;

    // Mode codes; 7 is never loaded and renders as IDLE.
    localparam logic [2:0] MODE_IDLE      = 3'd0;
    localparam logic [2:0] MODE_HZRD      = 3'd1;
    localparam logic [2:0] MODE_SIG_L     = 3'd2;
    localparam logic [2:0] MODE_SIG_R     = 3'd3;
    localparam logic [2:0] MODE_BRK       = 3'd4;
    localparam logic [2:0] MODE_BRK_SIG_L = 3'd5;
    localparam logic [2:0] MODE_BRK_SIG_R = 3'd6;

    // Lamp patterns; bit0 is the innermost lamp.
    localparam logic [2:0] PAT_OFF = 3'b000;
    localparam logic [2:0] PAT_ALL = 3'b111;
    localparam logic [2:0] PAT_S0  = 3'b000;
    localparam logic [2:0] PAT_S1  = 3'b001;
    localparam logic [2:0] PAT_S2  = 3'b011;
    localparam logic [2:0] PAT_S3  = 3'b111;

    // Synchronized control bundle.
    typedef struct packed {
        logic hazard;
        logic turn_en;
        logic dir_left;
        logic brake;
    } ctl_t;

    // Left/right lamp pair.
    typedef struct packed {
        logic [2:0] l;
        logic [2:0] r;
    } lamps_t;

    // Priority resolution of the controls into a mode code.
    function automatic logic [2:0] resolve_mode(input ctl_t c);
        logic [2:0] m;
        if (c.hazard)
            m = MODE_HZRD;
        else if (c.brake && c.turn_en)
            m = c.dir_left ? MODE_BRK_SIG_L : MODE_BRK_SIG_R;
        else if (c.brake)
            m = MODE_BRK;
        else if (c.turn_en)
            m = c.dir_left ? MODE_SIG_L : MODE_SIG_R;
        else
            m = MODE_IDLE;
        return m;
    endfunction

    // Turning-side sweep for a given step.
    function automatic logic [2:0] sig_pat(input logic [1:0] step);
        logic [2:0] p;
        case (step)
            2'd0:    p = PAT_S0;
            2'd1:    p = PAT_S1;
            2'd2:    p = PAT_S2;
            default: p = PAT_S3;
        endcase
        return p;
    endfunction

    // Lamp state for a mode/step pair; unknown codes fall back to IDLE.
    function automatic lamps_t lamp_pattern(input logic [2:0] mode, input logic [1:0] step);
        lamps_t o;
        o.l = PAT_OFF;
        o.r = PAT_OFF;
        case (mode)
            MODE_HZRD: begin
                o.l = step[0] ? PAT_OFF : PAT_ALL;
                o.r = step[0] ? PAT_OFF : PAT_ALL;
            end
            MODE_SIG_L:     o.l = sig_pat(step);
            MODE_SIG_R:     o.r = sig_pat(step);
            MODE_BRK: begin
                o.l = PAT_ALL;
                o.r = PAT_ALL;
            end
            MODE_BRK_SIG_L: begin
                o.l = sig_pat(step);
                o.r = PAT_ALL;
            end
            MODE_BRK_SIG_R: begin
                o.l = PAT_ALL;
                o.r = sig_pat(step);
            end
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running step divider: one-cycle tick every TICK_DIV clocks, clearable.
module tick_divider
    import taillight_pkg::*;
#(
    parameter int TICK_DIV = 1000000
) (
    input  logic ADC_CLK_10,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int              CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0]   LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    // Count 0..TICK_DIV-1, wrap on tick, restart on a mode change.
    always_ff @(posedge ADC_CLK_10 or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clr || tick)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/taillight_sequencer.sv
// Taillight controller: input sync, priority mode select, stepped lamp patterns.
module taillight_sequencer
    import taillight_pkg::*;
#(
    parameter int TICK_DIV = 1000000
) (
    input  logic       ADC_CLK_10,
    input  logic       reset,
    input  logic       hazard,
    input  logic       turn_en,
    input  logic       dir_left,
    input  logic       brake,
    output logic [2:0] led_l,
    output logic [2:0] led_r,
    output logic [2:0] mode,
    output logic       tick
);

    ctl_t       ctl_raw;
    ctl_t       ctl_s1;
    ctl_t       ctl_s2;
    logic [2:0] req_mode;
    logic       mode_chg;
    logic [1:0] step;
    logic [1:0] nxt_step;
    lamps_t     nxt_lamps;

    assign ctl_raw = {hazard, turn_en, dir_left, brake};

    // Two-flop synchronizer for the asynchronous switch/key inputs.
    always_ff @(posedge ADC_CLK_10 or posedge reset) begin
        if (reset) begin
            ctl_s1 <= '0;
            ctl_s2 <= '0;
        end else begin
            ctl_s1 <= ctl_raw;
            ctl_s2 <= ctl_s1;
        end
    end

    assign req_mode = resolve_mode(ctl_s2);
    assign mode_chg = (req_mode != mode);

    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_div (
        .ADC_CLK_10 (ADC_CLK_10),
        .reset      (reset),
        .clr        (mode_chg),
        .tick       (tick)
    );

    // Next step: a mode change restarts the sweep and overrides a coincident tick.
    always_comb begin
        nxt_step = step;
        if (mode_chg)
            nxt_step = 2'd0;
        else if (tick)
            nxt_step = step + 2'd1;
    end

    // Next mode is always the requested one, so lamps are decoded from it.
    assign nxt_lamps = lamp_pattern(req_mode, nxt_step);

    // Mode/step state and registered lamp outputs.
    always_ff @(posedge ADC_CLK_10 or posedge reset) begin
        if (reset) begin
            mode  <= MODE_IDLE;
            step  <= 2'd0;
            led_l <= PAT_OFF;
            led_r <= PAT_OFF;
        end else begin
            mode  <= req_mode;
            step  <= nxt_step;
            led_l <= nxt_lamps.l;
            led_r <= nxt_lamps.r;
        end
    end

endmodule
